// File: rtl/fcfs_request_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fcfs_request_queue
//  Description : Arrival-order request capture. Each new requester ID is
//                written into a ring-buffer FIFO; the oldest entry is
//                presented as a registered one-hot grant with valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module fcfs_request_queue #(
    parameter  int NUM_REQUESTS = 4,
    localparam int IDW          = $clog2(NUM_REQUESTS),
    localparam int CW           = $clog2(NUM_REQUESTS + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQUESTS-1:0] req_in,
    output logic [NUM_REQUESTS-1:0] grant_out,
    output logic [IDW-1:0]          grant_id,
    output logic                    grant_valid,
    input  logic                    grant_ready,
    output logic [NUM_REQUESTS-1:0] pending,
    output logic [CW-1:0]           count
);

    localparam logic [IDW-1:0] c_last_idx = IDW'(NUM_REQUESTS - 1);
    localparam logic [NUM_REQUESTS-1:0] c_one = NUM_REQUESTS'(1);

    // Reset synchroniser: assertion takes effect immediately, release is
    // aligned to clk so no flop leaves reset on a partial cycle.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    // Two-stage release synchroniser for the core reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    logic [IDW-1:0]          r_mem [NUM_REQUESTS];
    logic [IDW-1:0]          r_rd_ptr;
    logic [IDW-1:0]          r_wr_ptr;
    logic [CW-1:0]           r_count;
    logic [NUM_REQUESTS-1:0] r_pending;
    logic [NUM_REQUESTS-1:0] r_grant_out;
    logic [IDW-1:0]          r_grant_id;
    logic                    r_grant_valid;

    logic [IDW-1:0]          w_mem_next [NUM_REQUESTS];
    logic [NUM_REQUESTS-1:0] w_new;
    logic [IDW-1:0]          w_wr_next;
    logic [CW-1:0]           w_push_cnt;
    logic                    w_pop;
    logic [IDW-1:0]          w_rd_next;
    logic [CW-1:0]           w_count_next;
    logic [IDW-1:0]          w_head_next;
    logic                    w_valid_next;
    logic [NUM_REQUESTS-1:0] w_pending_next;

    // Enqueue all newly arriving requesters in ascending index order,
    // each taking the next ring slot after the previous one.
    always_comb begin
        w_new      = req_in & ~r_pending;
        w_mem_next = r_mem;
        w_wr_next  = r_wr_ptr;
        w_push_cnt = '0;
        for (int i = 0; i < NUM_REQUESTS; i++) begin
            if (w_new[i]) begin
                w_mem_next[w_wr_next] = IDW'(i);
                w_push_cnt            = w_push_cnt + CW'(1);
                w_wr_next             = (w_wr_next == c_last_idx) ? '0 : w_wr_next + IDW'(1);
            end
        end
    end

    // Dequeue, occupancy and the next registered head. The popped slot can
    // never be a write target: a full queue means every requester is pending.
    always_comb begin
        w_pop          = r_grant_valid & grant_ready;
        w_rd_next      = r_rd_ptr;
        if (w_pop) begin
            w_rd_next  = (r_rd_ptr == c_last_idx) ? '0 : r_rd_ptr + IDW'(1);
        end
        w_count_next   = r_count - CW'(w_pop) + w_push_cnt;
        w_valid_next   = (w_count_next != '0);
        w_head_next    = w_valid_next ? w_mem_next[w_rd_next] : '0;
        // The popped requester stays pending at the pop edge, so it is
        // not part of w_new and re-enqueues one edge later at the tail.
        w_pending_next = (r_pending & ~(w_pop ? r_grant_out : '0)) | w_new;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < NUM_REQUESTS; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_pending     <= '0;
            r_grant_out   <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
        end else begin
            r_mem         <= w_mem_next;
            r_rd_ptr      <= w_rd_next;
            r_wr_ptr      <= w_wr_next;
            r_count       <= w_count_next;
            r_pending     <= w_pending_next;
            r_grant_out   <= w_valid_next ? (c_one << w_head_next) : '0;
            r_grant_id    <= w_head_next;
            r_grant_valid <= w_valid_next;
        end
    end

    assign grant_out   = r_grant_out;
    assign grant_id    = r_grant_id;
    assign grant_valid = r_grant_valid;
    assign pending     = r_pending;
    assign count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fcfs_request_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fcfs_request_queue
//  Description : Scoreboard bench for fcfs_request_queue (N=4 and N=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fcfs_request_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [3:0] req;
    logic       ready;
    logic [3:0] gnt;
    logic [1:0] gid;
    logic       gvalid;
    logic [3:0] pend;
    logic [2:0] cnt;

    logic [2:0] req3;
    logic       ready3;
    logic [2:0] gnt3;
    logic [1:0] gid3;
    logic       gvalid3;
    logic [2:0] pend3;
    logic [1:0] cnt3;

    fcfs_request_queue #(.NUM_REQUESTS(4)) dut (
        .clk(clk), .reset_n(reset_n), .req_in(req), .grant_out(gnt),
        .grant_id(gid), .grant_valid(gvalid), .grant_ready(ready),
        .pending(pend), .count(cnt)
    );

    fcfs_request_queue #(.NUM_REQUESTS(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .req_in(req3), .grant_out(gnt3),
        .grant_id(gid3), .grant_valid(gvalid3), .grant_ready(ready3),
        .pending(pend3), .count(cnt3)
    );

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int exp3_q[$];
    bit chk_cnt2 = 1'b0;
    int e_id;
    int e3_id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the 4-requester instance: every accepted grant is
    // compared with the front of the expected-order queue.
    always @(negedge clk) begin
        if (gvalid && ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_grant: got id %0d, expected none", gid);
            end else begin
                e_id = exp_q.pop_front();
                chk("grant_id", 32'(gid), 32'(e_id));
                chk("grant_onehot", 32'(gnt), 32'(1) << e_id);
            end
        end
        if (chk_cnt2) chk("count_le2", 32'(cnt <= 3'd2), 32'd1);
    end

    // Monitor for the 3-requester instance.
    always @(negedge clk) begin
        if (gvalid3 && ready3) begin
            if (exp3_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_grant3: got id %0d, expected none", gid3);
            end else begin
                e3_id = exp3_q.pop_front();
                chk("grant3_id", 32'(gid3), 32'(e3_id));
                chk("grant3_onehot", 32'(gnt3), 32'(1) << e3_id);
            end
        end
    end

    task automatic wait_empty(input string name);
        for (int i = 0; i < 60 && gvalid; i++) tick();
        chk(name, 32'(gvalid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; req = '0; ready = 1'b0; req3 = '0; ready3 = 1'b0;
        repeat (3) tick();
        chk("in_reset_valid", 32'(gvalid), 32'd0);
        reset_n = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 32'(gvalid), 32'd0);
        chk("rst_grant", 32'(gnt), 32'd0);
        chk("rst_id", 32'(gid), 32'd0);
        chk("rst_count", 32'(cnt), 32'd0);
        chk("rst_pending", 32'(pend), 32'd0);

        // Single request, held head while not ready.
        req = 4'b0100;
        tick();
        req = 4'b0000;
        chk("t1_valid", 32'(gvalid), 32'd1);
        chk("t1_grant", 32'(gnt), 32'h4);
        chk("t1_id", 32'(gid), 32'd2);
        chk("t1_count", 32'(cnt), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_hold_grant", 32'(gnt), 32'h4);
            chk("t1_hold_id", 32'(gid), 32'd2);
        end
        exp_q.push_back(2);
        ready = 1'b1;
        wait_empty("t1_drained");
        chk("t1_count0", 32'(cnt), 32'd0);

        // Staggered arrivals served in arrival order.
        ready = 1'b0;
        req = 4'b0010; tick();
        req = 4'b1000; tick();
        req = 4'b0001; tick();
        req = 4'b0000;
        exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(0);
        ready = 1'b1;
        wait_empty("t2_drained");
        chk("t2_count0", 32'(cnt), 32'd0);

        // All requesters in one cycle: ascending index order.
        ready = 1'b0;
        req = 4'b1111; tick();
        req = 4'b0000;
        chk("t3_count", 32'(cnt), 32'd4);
        chk("t3_pending", 32'(pend), 32'hF);
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        ready = 1'b1;
        wait_empty("t3_drained");
        chk("t3_pending0", 32'(pend), 32'd0);

        // Held request 1 with request 3 arriving: strict alternation.
        for (int i = 0; i < 9; i++) exp_q.push_back((i % 2 == 0) ? 1 : 3);
        req = 4'b0010; tick();
        req = 4'b1010;
        chk_cnt2 = 1'b1;
        repeat (8) tick();
        req = 4'b0000;
        wait_empty("t4_drained");
        chk_cnt2 = 1'b0;
        chk("t4_left", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a handshake discards the queue.
        ready = 1'b0;
        req = 4'b0111; tick();
        req = 4'b0000;
        chk("t6_count", 32'(cnt), 32'd3);
        ready = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("t6_valid", 32'(gvalid), 32'd0);
        chk("t6_grant", 32'(gnt), 32'd0);
        chk("t6_id", 32'(gid), 32'd0);
        chk("t6_count0", 32'(cnt), 32'd0);
        chk("t6_pending", 32'(pend), 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        chk("t6_no_stale", 32'(gvalid), 32'd0);
        exp_q.push_back(3);
        req = 4'b1000; tick();
        req = 4'b0000;
        wait_empty("t6_drained");

        // N=3 continuous traffic: round-robin order across many wraps.
        for (int i = 0; i < 33; i++) exp3_q.push_back(i % 3);
        ready3 = 1'b1;
        req3 = 3'b111;
        repeat (32) tick();
        req3 = 3'b000;
        for (int i = 0; i < 60 && gvalid3; i++) tick();
        chk("t5_drained", 32'(gvalid3), 32'd0);
        chk("t5_count0", 32'(cnt3), 32'd0);
        chk("t5_left", 32'(exp3_q.size()), 32'd0);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
